// File: rtl/elevator_pkg.sv
// Shared types for the elevator scheduler: FSM state encoding and travel direction constants.
package elevator_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        MOVE_UP   = 3'd1,
        MOVE_DOWN = 3'd2,
        DOOR_OPEN = 3'd3,
        ERROR     = 3'd4
    } state_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/elevator_down_timer.sv
// Loadable down-counter that can be frozen; expire is high during the final counted cycle
// (count == 1 while running). A load takes priority over counting.
module elevator_down_timer #(
    parameter int MAX_COUNT = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic load,
    input  logic run,
    output logic expire
);

    localparam int CNT_W = $clog2(MAX_COUNT + 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= CNT_W'(MAX_COUNT);
        end else if (run && count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

    assign expire = run && (count == CNT_W'(1));

endmodule

// File: rtl/elevator_sched_fsm.sv
// SCAN elevator scheduler with a pending-request bitmap, travel/door timers and a freezing ERROR state.
// Optional feature macro: ELEVATOR_SCHED_DOOR_HOLD_EN adds i_sched_door_hold to keep the door open.
module elevator_sched_fsm
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS    = 8,
    parameter int FLOOR_W       = $clog2(NUM_FLOORS),
    parameter int TRAVEL_CYCLES = 8,
    parameter int DOOR_CYCLES   = 16
) (
    input  logic                  i_sched_clock,
    input  logic                  i_sched_reset,
    input  logic                  i_sched_req_valid,
    input  logic [FLOOR_W-1:0]    i_sched_req_floor,
    input  logic                  i_sched_error_flag,
    input  logic                  i_sched_error_clear,
    output logic                  o_sched_move_up,
    output logic                  o_sched_move_down,
    output logic                  o_sched_open_door,
    output logic                  o_sched_alarm,
    output logic [FLOOR_W-1:0]    o_sched_floor,
    output logic [NUM_FLOORS-1:0] o_sched_pending,
    output logic                  o_sched_req_err
`ifdef ELEVATOR_SCHED_DOOR_HOLD_EN
    ,
    input  logic                  i_sched_door_hold
`endif
);

    state_t state, state_next, saved_state, saved_next;
    logic dir, dir_next;
    logic [FLOOR_W-1:0] floor, floor_next, step_floor;
    logic [NUM_FLOORS-1:0] pending, pending_next, set_mask, clr_mask, here_onehot, step_onehot;
    logic above, below, here_pending, step_pending, req_in_range, req_here, req_step;
    logic travel_load, travel_run, travel_expire;
    logic door_load, door_run, door_expire, door_hold;

`ifdef ELEVATOR_SCHED_DOOR_HOLD_EN
    assign door_hold = i_sched_door_hold;
`else
    assign door_hold = 1'b0;
`endif

    elevator_down_timer #(.MAX_COUNT(TRAVEL_CYCLES)) travel_timer (
        .clock  (i_sched_clock),
        .reset  (i_sched_reset),
        .load   (travel_load),
        .run    (travel_run),
        .expire (travel_expire)
    );

    elevator_down_timer #(.MAX_COUNT(DOOR_CYCLES)) door_timer (
        .clock  (i_sched_clock),
        .reset  (i_sched_reset),
        .load   (door_load),
        .run    (door_run),
        .expire (door_expire)
    );

    // step_floor is where the car lands when the current travel interval expires.
    always_comb begin
        above        = 1'b0;
        below        = 1'b0;
        here_pending = 1'b0;
        step_pending = 1'b0;
        set_mask     = '0;
        here_onehot  = '0;
        step_onehot  = '0;
        req_in_range = int'(i_sched_req_floor) < NUM_FLOORS;
        step_floor   = floor;
        if (state == MOVE_UP && int'(floor) < NUM_FLOORS - 1) begin
            step_floor = floor + FLOOR_W'(1);
        end else if (state == MOVE_DOWN && floor != '0) begin
            step_floor = floor - FLOOR_W'(1);
        end
        for (int i = 0; i < NUM_FLOORS; i++) begin
            here_onehot[i] = (int'(floor) == i);
            step_onehot[i] = (int'(step_floor) == i);
            set_mask[i]    = i_sched_req_valid && (int'(i_sched_req_floor) == i);
            if (pending[i] && i > int'(floor)) above = 1'b1;
            if (pending[i] && i < int'(floor)) below = 1'b1;
        end
        here_pending = |(pending & here_onehot);
        step_pending = |(pending & step_onehot);
        req_here     = i_sched_req_valid && (i_sched_req_floor == floor);
        req_step     = i_sched_req_valid && (i_sched_req_floor == step_floor);
        if (state == DOOR_OPEN && req_here) set_mask = '0;
    end

    always_comb begin
        state_next  = state;
        saved_next  = saved_state;
        dir_next    = dir;
        floor_next  = floor;
        clr_mask    = '0;
        travel_load = 1'b0;
        travel_run  = 1'b0;
        door_load   = 1'b0;
        door_run    = 1'b0;
        if (state != ERROR && i_sched_error_flag) begin
            state_next = ERROR;
            saved_next = state;
        end else begin
            case (state)
                IDLE: begin
                    if (here_pending) begin
                        state_next = DOOR_OPEN;
                        clr_mask   = here_onehot;
                        door_load  = 1'b1;
                    end else if ((dir == DIR_UP && above) || (dir == DIR_DOWN && below)) begin
                        state_next  = (dir == DIR_UP) ? MOVE_UP : MOVE_DOWN;
                        travel_load = 1'b1;
                    end else if (above) begin
                        dir_next    = DIR_UP;
                        state_next  = MOVE_UP;
                        travel_load = 1'b1;
                    end else if (below) begin
                        dir_next    = DIR_DOWN;
                        state_next  = MOVE_DOWN;
                        travel_load = 1'b1;
                    end
                end
                MOVE_UP, MOVE_DOWN: begin
                    travel_run = 1'b1;
                    if (travel_expire) begin
                        floor_next  = step_floor;
                        travel_load = 1'b1;
                        if (step_pending || req_step) begin
                            state_next = DOOR_OPEN;
                            clr_mask   = step_onehot;
                            door_load  = 1'b1;
                        end
                    end
                end
                DOOR_OPEN: begin
                    if (req_here || door_hold) begin
                        door_load = 1'b1;
                    end else begin
                        door_run = 1'b1;
                        if (door_expire) state_next = IDLE;
                    end
                end
                ERROR: begin
                    // Timers are neither loaded nor run here, so they resume with their frozen values.
                    if (i_sched_error_clear && !i_sched_error_flag) state_next = saved_state;
                end
                default: state_next = IDLE;
            endcase
        end
        pending_next = (pending | (req_in_range ? set_mask : '0)) & ~clr_mask;
    end

    always_ff @(posedge i_sched_clock) begin
        if (i_sched_reset) begin
            state             <= IDLE;
            saved_state       <= IDLE;
            dir               <= DIR_UP;
            floor             <= '0;
            pending           <= '0;
            o_sched_move_up   <= 1'b0;
            o_sched_move_down <= 1'b0;
            o_sched_open_door <= 1'b0;
            o_sched_alarm     <= 1'b0;
            o_sched_req_err   <= 1'b0;
        end else begin
            state             <= state_next;
            saved_state       <= saved_next;
            dir               <= dir_next;
            floor             <= floor_next;
            pending           <= pending_next;
            o_sched_move_up   <= (state_next == MOVE_UP);
            o_sched_move_down <= (state_next == MOVE_DOWN);
            o_sched_open_door <= (state_next == DOOR_OPEN);
            o_sched_alarm     <= (state_next == ERROR);
            o_sched_req_err   <= i_sched_req_valid && !req_in_range;
        end
    end

    assign o_sched_floor   = floor;
    assign o_sched_pending = pending;

endmodule

// File: tb/tb_elevator_sched_fsm.sv
// Self-checking bench for elevator_sched_fsm: directed scenarios plus randomized traffic,
// every cycle compared against a behavioural reference model.
module tb_elevator_sched_fsm;

    localparam int NF = 8;
    localparam int FW = 4;
    localparam int TC = 4;
    localparam int DC = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req_valid = 1'b0;
    logic [FW-1:0] req_floor = '0;
    logic err_flag = 1'b0;
    logic err_clear = 1'b0;
    logic move_up, move_down, open_door, alarm, req_err;
    logic [FW-1:0] floor;
    logic [NF-1:0] pending;
`ifdef ELEVATOR_SCHED_DOOR_HOLD_EN
    logic door_hold = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    always #5 clk = ~clk;

    elevator_sched_fsm #(
        .NUM_FLOORS(NF), .FLOOR_W(FW), .TRAVEL_CYCLES(TC), .DOOR_CYCLES(DC)
    ) dut (
        .i_sched_clock      (clk),
        .i_sched_reset      (rst),
        .i_sched_req_valid  (req_valid),
        .i_sched_req_floor  (req_floor),
        .i_sched_error_flag (err_flag),
        .i_sched_error_clear(err_clear),
        .o_sched_move_up    (move_up),
        .o_sched_move_down  (move_down),
        .o_sched_open_door  (open_door),
        .o_sched_alarm      (alarm),
        .o_sched_floor      (floor),
        .o_sched_pending    (pending),
        .o_sched_req_err    (req_err)
`ifdef ELEVATOR_SCHED_DOOR_HOLD_EN
        ,
        .i_sched_door_hold  (door_hold)
`endif
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Reference model: one "activity" countdown per mode and an array of pending floors.
    typedef enum int {M_IDLE, M_UP, M_DOWN, M_DOOR, M_ALARM} mmode_t;
    mmode_t m_mode = M_IDLE;
    mmode_t m_resume = M_IDLE;
    int m_floor = 0;
    bit m_up = 1'b1;
    bit m_pend [NF];
    int m_left = 0;
    bit m_req_err = 1'b0;

    always @(posedge clk) begin : model
        int rf;
        int served;
        bit req_ok, do_set, has_above, has_below;
        if (rst) begin
            m_mode = M_IDLE;
            m_resume = M_IDLE;
            m_floor = 0;
            m_up = 1'b1;
            foreach (m_pend[i]) m_pend[i] = 1'b0;
            m_left = 0;
            m_req_err = 1'b0;
        end else begin
            rf = int'(req_floor);
            req_ok = req_valid && rf < NF;
            m_req_err = req_valid && !req_ok;
            do_set = req_ok && !(m_mode == M_DOOR && rf == m_floor);
            served = -1;
            if (m_mode == M_ALARM) begin
                if (err_clear && !err_flag) m_mode = m_resume;
            end else if (err_flag) begin
                m_resume = m_mode;
                m_mode = M_ALARM;
            end else begin
                case (m_mode)
                    M_IDLE: begin
                        has_above = 1'b0;
                        has_below = 1'b0;
                        foreach (m_pend[i]) begin
                            if (m_pend[i] && i > m_floor) has_above = 1'b1;
                            if (m_pend[i] && i < m_floor) has_below = 1'b1;
                        end
                        if (m_pend[m_floor]) begin
                            served = m_floor;
                            m_mode = M_DOOR;
                            m_left = DC;
                        end else if (has_above || has_below) begin
                            if (!((m_up && has_above) || (!m_up && has_below))) m_up = !m_up;
                            m_mode = m_up ? M_UP : M_DOWN;
                            m_left = TC;
                        end
                    end
                    M_UP, M_DOWN: begin
                        m_left--;
                        if (m_left == 0) begin
                            m_floor += (m_mode == M_UP) ? 1 : -1;
                            m_left = TC;
                            if (m_pend[m_floor] || (req_ok && rf == m_floor)) begin
                                served = m_floor;
                                m_mode = M_DOOR;
                                m_left = DC;
                            end
                        end
                    end
                    M_DOOR: begin
                        if (req_ok && rf == m_floor) begin
                            m_left = DC;
                        end else begin
                            m_left--;
                            if (m_left == 0) m_mode = M_IDLE;
                        end
                    end
                    default: ;
                endcase
            end
            if (do_set) m_pend[rf] = 1'b1;
            if (served >= 0) m_pend[served] = 1'b0;
        end
    end

    always @(negedge clk) begin
        logic [NF-1:0] pv;
        if (check_en) begin
            foreach (m_pend[i]) pv[i] = m_pend[i];
            checkOutput("model_move_up", 32'(move_up), 32'(m_mode == M_UP));
            checkOutput("model_move_down", 32'(move_down), 32'(m_mode == M_DOWN));
            checkOutput("model_open_door", 32'(open_door), 32'(m_mode == M_DOOR));
            checkOutput("model_alarm", 32'(alarm), 32'(m_mode == M_ALARM));
            checkOutput("model_floor", 32'(floor), 32'(m_floor));
            checkOutput("model_pending", 32'(pending), 32'(pv));
            checkOutput("model_req_err", 32'(req_err), 32'(m_req_err));
        end
    end

    task automatic applyStimulus(input logic v, input logic [FW-1:0] f, input logic ef, input logic ec);
        req_valid = v;
        req_floor = f;
        err_flag  = ef;
        err_clear = ec;
        @(negedge clk);
    endtask

    task automatic idleCycles(input int n);
        repeat (n) applyStimulus(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic waitDoor(input int bound);
        int k = 0;
        while (!open_door && k < bound) begin
            idleCycles(1);
            k++;
        end
        checkOutput("door_reached", 32'(open_door), 32'(1));
    endtask

    task automatic waitQuiet(input int bound);
        int k = 0;
        while ((open_door || move_up || move_down || pending != '0) && k < bound) begin
            idleCycles(1);
            k++;
        end
        checkOutput("quiet_reached", 32'(open_door || move_up || move_down || pending != '0), 32'(0));
    endtask

    initial begin
        logic r_valid, r_flag, r_clear;
        logic [FW-1:0] r_floor;
        int err_left;
        logic [NF-1:0] pend_before;

        repeat (2) @(negedge clk);
        check_en = 1'b1;
        checkOutput("rst_floor", 32'(floor), 32'(0));
        checkOutput("rst_pending", 32'(pending), 32'(0));
        checkOutput("rst_outputs", 32'({move_up, move_down, open_door, alarm, req_err}), 32'(0));
        rst = 1'b0;

        // Scenario 1: single request for floor 3 from reset.
        applyStimulus(1'b1, 4'd3, 1'b0, 1'b0);
        checkOutput("t1_pending", 32'(pending), 32'h08);
        checkOutput("t1_move_early", 32'(move_up), 32'(0));
        idleCycles(1);
        checkOutput("t1_move_start", 32'(move_up), 32'(1));
        idleCycles(3);
        checkOutput("t1_floor0", 32'(floor), 32'(0));
        idleCycles(1);
        checkOutput("t1_floor1", 32'(floor), 32'(1));
        idleCycles(4);
        checkOutput("t1_floor2", 32'(floor), 32'(2));
        idleCycles(4);
        checkOutput("t1_floor3", 32'(floor), 32'(3));
        checkOutput("t1_door", 32'(open_door), 32'(1));
        checkOutput("t1_stopped", 32'(move_up), 32'(0));
        checkOutput("t1_pending_clr", 32'(pending), 32'(0));
        idleCycles(5);
        checkOutput("t1_door_last", 32'(open_door), 32'(1));
        idleCycles(1);
        checkOutput("t1_door_closed", 32'(open_door), 32'(0));

        // Scenario 2: pending above and below while heading up; SCAN serves above first.
        applyStimulus(1'b1, 4'd5, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'd0, 1'b0, 1'b0);
        waitDoor(100);
        checkOutput("t2_first_stop", 32'(floor), 32'(5));
        while (open_door) idleCycles(1);
        waitDoor(100);
        checkOutput("t2_second_stop", 32'(floor), 32'(0));
        waitQuiet(100);

        // Scenario 3: error mid-move with two travel cycles left.
        applyStimulus(1'b1, 4'd3, 1'b0, 1'b0);
        idleCycles(1);
        checkOutput("t3_moving", 32'(move_up), 32'(1));
        idleCycles(2);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, '0, 1'b1, 1'b0);
            checkOutput("t3_alarm", 32'(alarm), 32'(1));
            checkOutput("t3_frozen_floor", 32'(floor), 32'(0));
            checkOutput("t3_motor_off", 32'(move_up), 32'(0));
        end
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        checkOutput("t3_resume", 32'(move_up), 32'(1));
        checkOutput("t3_alarm_off", 32'(alarm), 32'(0));
        idleCycles(1);
        checkOutput("t3_still_floor0", 32'(floor), 32'(0));
        idleCycles(1);
        checkOutput("t3_floor1", 32'(floor), 32'(1));

        // Scenario 4: clear while the flag is still high keeps the alarm.
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, '0, 1'b1, 1'b1);
            checkOutput("t4_alarm_held", 32'(alarm), 32'(1));
        end
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        checkOutput("t4_alarm_off", 32'(alarm), 32'(0));
        checkOutput("t4_resume", 32'(move_up), 32'(1));
        waitDoor(100);
        checkOutput("t4_stop", 32'(floor), 32'(3));
        waitQuiet(100);

        // Scenario 5: out-of-range request.
        pend_before = pending;
        applyStimulus(1'b1, 4'd9, 1'b0, 1'b0);
        checkOutput("t5_req_err", 32'(req_err), 32'(1));
        checkOutput("t5_pending", 32'(pending), 32'(pend_before));
        idleCycles(1);
        checkOutput("t5_req_err_pulse", 32'(req_err), 32'(0));

        // Scenario 6: same-floor re-request in the door's 5th cycle.
        applyStimulus(1'b1, 4'd4, 1'b0, 1'b0);
        waitDoor(100);
        checkOutput("t6_floor", 32'(floor), 32'(4));
        idleCycles(4);
        applyStimulus(1'b1, 4'd4, 1'b0, 1'b0);
        checkOutput("t6_no_pending", 32'(pending), 32'(0));
        checkOutput("t6_door_held", 32'(open_door), 32'(1));
        idleCycles(5);
        checkOutput("t6_door_last", 32'(open_door), 32'(1));
        idleCycles(1);
        checkOutput("t6_door_closed", 32'(open_door), 32'(0));

        // Randomized traffic with error bursts and occasional resets.
        err_left = 0;
        for (int c = 0; c < 3000; c++) begin
            r_valid = ($urandom_range(0, 4) == 0);
            r_floor = FW'($urandom_range(0, 9));
            if (err_left == 0 && $urandom_range(0, 60) == 0) err_left = $urandom_range(1, 6);
            r_flag = (err_left > 0);
            if (err_left > 0) err_left--;
            r_clear = 1'($urandom_range(0, 1));
            rst = ($urandom_range(0, 700) == 0);
            applyStimulus(r_valid, r_floor, r_flag, r_clear);
        end
        rst = 1'b0;
        idleCycles(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
